// File: rtl/fft_reorder_buf.sv
// Ping-pong frame buffer: captures corefft bins and replays each frame in natural order over valid/ready.
// Optional define FFT_REORDER_BITREV_EN selects bit-reversed write addressing; otherwise order is preserved.
module fft_reorder_buf #(
    parameter int WIDTH = 16,
    parameter int N     = 9
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_en,
    input  logic [N-1:0]     in_cnt,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_idx,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_last,
    output logic             frame_drop
);
    localparam int DW = 2 * WIDTH;
    localparam logic [N-1:0] LAST = {N{1'b1}};

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} r_state_e;

    logic [DW-1:0] mem [0:(2**(N+1))-1];
    logic [DW-1:0] ram_rd_q;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic [1:0] full_q, full_d;
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, fb_q, fb_d;
    logic frame_drop_q, frame_drop_d;
    logic [N-1:0] ra_q, ra_d, pend_idx_q, pend_idx_d;
    logic pend_q, pend_d;
    logic ov_q, ov_d, sv_q, sv_d;
    logic [N-1:0] oidx_q, oidx_d, sidx_q, sidx_d;
    logic [DW-1:0] odat_q, odat_d, sdat_q, sdat_d;
    logic [N-1:0] wa;
    logic we, wr_set, rd_clr, rd_issue, pop;

`ifdef FFT_REORDER_BITREV_EN
    always_comb begin
        for (int i = 0; i < N; i++) wa[i] = in_cnt[N-1-i];
    end
`else
    assign wa = in_cnt;
`endif

    // Write side: accept a frame only when it starts at bin 0 into a free bank.
    always_comb begin
        w_state_d    = w_state_q;
        wr_bank_d    = wr_bank_q;
        we           = 1'b0;
        wr_set       = 1'b0;
        frame_drop_d = 1'b0;
        if (in_en) begin
            unique case (w_state_q)
                W_IDLE: if (in_cnt == '0) begin
                    if (!full_q[wr_bank_q]) begin
                        we        = 1'b1;
                        w_state_d = W_FILL;
                    end else begin
                        frame_drop_d = 1'b1;
                        w_state_d    = W_DROP;
                    end
                end
                W_FILL: begin
                    we = 1'b1;
                    if (in_cnt == LAST) begin
                        wr_set    = 1'b1;
                        wr_bank_d = !wr_bank_q;
                        w_state_d = W_IDLE;
                    end
                end
                W_DROP: if (in_cnt == LAST) w_state_d = W_IDLE;
                default: w_state_d = W_IDLE;
            endcase
        end
    end

    // Read side: RAM read stage feeds an output register backed by one skid entry.
    // fb_q is the bank being fetched; it runs ahead of rd_bank_q so frames chain without bubbles.
    always_comb begin
        pop    = ov_q && out_ready;
        ov_d   = ov_q;
        oidx_d = oidx_q;
        odat_d = odat_q;
        sv_d   = sv_q;
        sidx_d = sidx_q;
        sdat_d = sdat_q;
        if (!ov_q || pop) begin
            if (sv_q) begin
                ov_d   = 1'b1;
                oidx_d = sidx_q;
                odat_d = sdat_q;
                sv_d   = pend_q;
                if (pend_q) begin
                    sidx_d = pend_idx_q;
                    sdat_d = ram_rd_q;
                end
            end else if (pend_q) begin
                ov_d   = 1'b1;
                oidx_d = pend_idx_q;
                odat_d = ram_rd_q;
            end else begin
                ov_d = 1'b0;
            end
        end else if (pend_q) begin
            sv_d   = 1'b1;
            sidx_d = pend_idx_q;
            sdat_d = ram_rd_q;
        end

        rd_clr     = pop && (oidx_q == LAST);
        rd_issue   = full_q[fb_q] && !(ov_d && sv_d);
        pend_d     = rd_issue;
        pend_idx_d = ra_q;

        r_state_d = r_state_q;
        fb_d      = fb_q;
        ra_d      = ra_q;
        rd_bank_d = rd_bank_q;
        if (rd_issue) begin
            ra_d      = ra_q + 1'b1;
            r_state_d = R_FETCH;
            if (ra_q == LAST) begin
                fb_d      = !fb_q;
                r_state_d = R_STREAM;
            end
        end
        if (rd_clr) begin
            rd_bank_d = !rd_bank_q;
            if (r_state_d == R_STREAM) r_state_d = R_IDLE;
        end

        full_d = full_q;
        if (wr_set) full_d[wr_bank_q] = 1'b1;
        if (rd_clr) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            fb_q         <= 1'b0;
            frame_drop_q <= 1'b0;
            ra_q         <= '0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            ov_q         <= 1'b0;
            oidx_q       <= '0;
            odat_q       <= '0;
            sv_q         <= 1'b0;
            sidx_q       <= '0;
            sdat_q       <= '0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            fb_q         <= fb_d;
            frame_drop_q <= frame_drop_d;
            ra_q         <= ra_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            ov_q         <= ov_d;
            oidx_q       <= oidx_d;
            odat_q       <= odat_d;
            sv_q         <= sv_d;
            sidx_q       <= sidx_d;
            sdat_q       <= sdat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank_q, wa}] <= {in_re, in_im};
        if (rd_issue) ram_rd_q <= mem[{fb_q, ra_q}];
    end

    assign out_valid  = ov_q;
    assign out_idx    = oidx_q;
    assign out_re     = odat_q[DW-1:WIDTH];
    assign out_im     = odat_q[WIDTH-1:0];
    assign out_last   = ov_q && (oidx_q == LAST);
    assign frame_drop = frame_drop_q;
endmodule

// File: tb/tb_fft_reorder_buf.sv
// Scoreboard bench for fft_reorder_buf: frame-level model predicts accepted frames and natural-order readout.
module tb_fft_reorder_buf;
    localparam int WIDTH = 16;
    localparam int N     = 9;
    localparam int FL    = 1 << N;

    logic clk = 1'b0, areset = 1'b0, in_en = 1'b0, out_ready;
    logic [N-1:0] in_cnt = '0;
    logic [WIDTH-1:0] in_re = '0, in_im = '0;
    logic out_valid, out_last, frame_drop;
    logic [N-1:0] out_idx;
    logic [WIDTH-1:0] out_re, out_im;

    fft_reorder_buf #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .areset(areset), .in_en(in_en), .in_cnt(in_cnt),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_re(out_re), .out_im(out_im), .out_last(out_last),
        .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        bit last;
    } exp_t;

    exp_t q[$];
    int errs = 0, checks = 0, held = 0, exp_drops = 0, drops_seen = 0;
    int vcount = 0, first_v = -1, last_v = -1, cyc = 0;
    int rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Reference mapping: natural bin k was delivered with in_cnt = bitrev(k) when reordering is enabled.
    function automatic int src_cnt(input int k);
`ifdef FFT_REORDER_BITREV_EN
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if ((k >> i) & 1) r |= 1 << (N - 1 - i);
        return r;
`else
        return k;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) out_ready = 1'($urandom_range(1));
        else out_ready = (rdy_mode == 1);
    end

    task automatic send_sample(input int c, input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
        in_en = 1'b1; in_cnt = N'(c); in_re = re; in_im = im;
        @(posedge clk); #1;
        in_en = 1'b0;
    endtask

    // A frame is accepted iff fewer than two frames are held (being written or awaiting full readout).
    task automatic send_frame(input bit pattern, input int gap_pct);
        logic [WIDTH-1:0] fre[FL];
        logic [WIDTH-1:0] fim[FL];
        bit acc;
        exp_t e;
        acc = (held < 2);
        if (acc) held++; else exp_drops++;
        for (int c = 0; c < FL; c++) begin
            fre[c] = pattern ? WIDTH'(c * 10) : WIDTH'($urandom);
            fim[c] = pattern ? WIDTH'(-c) : WIDTH'($urandom);
            send_sample(c, fre[c], fim[c]);
            if (c == 0) chk(acc ? "no_drop" : "drop_pulse", 64'(frame_drop), 64'(!acc));
            if (c == 1 && !acc) chk("drop_width", 64'(frame_drop), 0);
            if (gap_pct > 0 && c != FL - 1)
                while ($urandom_range(99) < gap_pct) begin @(posedge clk); #1; end
        end
        if (acc)
            for (int k = 0; k < FL; k++) begin
                e.idx = k; e.re = fre[src_cnt(k)]; e.im = fim[src_cnt(k)]; e.last = (k == FL - 1);
                q.push_back(e);
            end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 20000) begin @(posedge clk); #1; t++; end
        chk("drain_timeout", 64'(t < 20000), 1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_idx", 64'(out_idx), 0);
        chk("rst_re", 64'(out_re), 0);
        chk("rst_im", 64'(out_im), 0);
        chk("rst_last", 64'(out_last), 0);
        chk("rst_drop", 64'(frame_drop), 0);
    endtask

    // Monitor: compares every transfer against the scoreboard and checks outputs hold under stall.
    logic prev_stall = 1'b0, p_last;
    logic [N-1:0] p_idx;
    logic [WIDTH-1:0] p_re, p_im;
    always @(negedge clk) begin
        exp_t e;
        if (!areset) prev_stall = 1'b0;
        else begin
            if (frame_drop) drops_seen++;
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 1);
                chk("hold_idx", 64'(out_idx), 64'(p_idx));
                chk("hold_re", 64'(out_re), 64'(p_re));
                chk("hold_im", 64'(out_im), 64'(p_im));
                chk("hold_last", 64'(out_last), 64'(p_last));
            end
            if (out_valid) begin
                vcount++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_out: idx %0d with empty scoreboard", out_idx);
                end else begin
                    checks--;
                    e = q.pop_front();
                    chk("out_idx", 64'(out_idx), 64'(e.idx));
                    chk("out_re", 64'(out_re), 64'(e.re));
                    chk("out_im", 64'(out_im), 64'(e.im));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    if (e.last) held--;
                end
            end
            prev_stall = out_valid && !out_ready;
            p_idx = out_idx; p_re = out_re; p_im = out_im; p_last = out_last;
        end
    end

    initial begin
        int d0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs();
        areset = 1'b1;
        rdy_mode = 1;
        @(posedge clk); #1;

        // Pattern frame and exact latency from the last-bin capture edge.
        send_frame(1'b1, 0);
        @(posedge clk); #1;
        chk("lat_e1_valid", 64'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_e2_valid", 64'(out_valid), 1);
        chk("lat_e2_idx", 64'(out_idx), 0);
        wait_drain();

        // Two back-to-back frames with a free-running reader: one unbroken valid run.
        vcount = 0; first_v = -1; last_v = -1; d0 = drops_seen;
        send_frame(1'b0, 0);
        send_frame(1'b0, 0);
        wait_drain();
        chk("b2b_count", 64'(vcount), 64'(2 * FL));
        chk("b2b_span", 64'(last_v - first_v + 1), 64'(2 * FL));
        chk("b2b_drops", 64'(drops_seen - d0), 0);

        // Stalled reader across three input frames: third frame is dropped.
        rdy_mode = 0;
        @(posedge clk); #1;
        d0 = drops_seen;
        repeat (3) send_frame(1'b0, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_drops", 64'(drops_seen - d0), 1);
        rdy_mode = 1;
        wait_drain();
        repeat (10) @(posedge clk);
        #1;
        chk("idle_after", 64'(out_valid), 0);

        // Random backpressure with random input gaps.
        rdy_mode = 2;
        repeat (6) send_frame(1'b0, 30);
        wait_drain();
        chk("rand_drops", 64'(drops_seen), 64'(exp_drops));

        // Reset while bin 100 is presented; rest of that frame must be ignored.
        rdy_mode = 1;
        @(posedge clk); #1;
        held = 1;
        for (int c = 0; c < 100; c++) send_sample(c, WIDTH'($urandom), WIDTH'($urandom));
        areset = 1'b0; in_en = 1'b1; in_cnt = N'(100);
        @(posedge clk); #1;
        areset = 1'b1; in_en = 1'b0;
        q.delete();
        held = 0;
        chk_reset_outs();
        for (int c = 101; c < FL; c++) send_sample(c, WIDTH'($urandom), WIDTH'($urandom));
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle", 64'(out_valid), 0);
        send_frame(1'b1, 0);
        wait_drain();
        chk("final_drops", 64'(drops_seen), 64'(exp_drops));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
